// File: rtl/acl_spi_pkg.sv
// Shared constants for the accelerometer-style SPI responder: command codes,
// register map addresses, reset values and the transaction FSM state encoding.
// Optional build macro used by the top level: ACL_RESP_SNAPSHOT_EN.
package acl_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } acl_state_e;

    localparam logic [7:0] CMD_WRITE       = 8'h0A;
    localparam logic [7:0] CMD_READ        = 8'h0B;

    localparam logic [7:0] ADDR_DEVID_AD   = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST  = 8'h01;
    localparam logic [7:0] ADDR_PARTID     = 8'h02;
    localparam logic [7:0] ADDR_XDATA_L    = 8'h0E;
    localparam logic [7:0] ADDR_XDATA_H    = 8'h0F;
    localparam logic [7:0] ADDR_YDATA_L    = 8'h10;
    localparam logic [7:0] ADDR_YDATA_H    = 8'h11;
    localparam logic [7:0] ADDR_ZDATA_L    = 8'h12;
    localparam logic [7:0] ADDR_ZDATA_H    = 8'h13;
    localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

    localparam logic [7:0] DEVID_MST_VAL   = 8'h1D;
    localparam logic [7:0] FILTER_CTL_RST  = 8'h13;
    localparam logic [7:0] POWER_CTL_RST   = 8'h00;

    // High byte of a 12-bit signed sample: sign bit replicated into the top nibble.
    function automatic logic [7:0] sx_hi(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous SPI line plus a third history
// flop used for rise/fall detection. RST_VAL is the idle level of the line.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // [0] metastable stage, [1] synchronized level, [2] previous level
    logic [2:0] sh_q, sh_d;

    // Shift the raw input into the synchronizer chain.
    always_comb begin
        sh_d = {sh_q[1:0], d_i};
    end

    // Synchronizer and history registers; reset to the idle level so no edge is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh_q <= {3{RST_VAL}};
        else     sh_q <= sh_d;
    end

    assign level_o = sh_q[1];
    assign rise_o  = sh_q[1] & ~sh_q[2];
    assign fall_o  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 register responder (ADXL362-like). Command byte, address byte,
// then data bytes with auto-incrementing address. Everything runs in the clk
// domain from synchronized SCLK/CSN/MOSI; clk must be at least 8x SCLK.
// Build option ACL_RESP_SNAPSHOT_EN: freeze axis samples at CSN fall.
module acl_spi_responder
    import acl_spi_pkg::*;
#(
    parameter logic [7:0] DEVID_AD = 8'hAD,
    parameter logic [7:0] PARTID   = 8'hF2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acl_sclk_i,
    input  logic        acl_csn_i,
    input  logic        acl_mosi_i,
    output logic        acl_miso_o,
    output logic        acl_miso_oe_o,
    input  logic [11:0] x_data_i,
    input  logic [11:0] y_data_i,
    input  logic [11:0] z_data_i,
    output logic [7:0]  filter_ctl_o,
    output logic [7:0]  power_ctl_o,
    output logic [2:0]  dbg_state_o
);

    logic sclk_lvl, sclk_rise_raw, sclk_fall;
    logic csn_lvl, csn_rise, csn_fall;
    logic sclk_rise;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(acl_sclk_i),
        .level_o(sclk_lvl), .rise_o(sclk_rise_raw), .fall_o(sclk_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_csn_sync (
        .clk(clk), .rst(rst), .d_i(acl_csn_i),
        .level_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall)
    );

    assign sclk_rise = sclk_rise_raw & sclk_lvl;

    // MOSI uses the same two-stage depth as SCLK so the sampled bit lines up with the rise.
    logic [1:0] mosi_q, mosi_d;
    logic       mosi_s;

    // Shift MOSI through its synchronizer.
    always_comb begin
        mosi_d = {mosi_q[0], acl_mosi_i};
    end

    // MOSI synchronizer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mosi_q <= 2'b00;
        else     mosi_q <= mosi_d;
    end

    assign mosi_s = mosi_q[1];

    logic [11:0] x_src, y_src, z_src;

`ifdef ACL_RESP_SNAPSHOT_EN
    logic [35:0] snap_q, snap_d;

    // Capture all three axes at the start of each transaction.
    always_comb begin
        snap_d = csn_fall ? {x_data_i, y_data_i, z_data_i} : snap_q;
    end

    // Snapshot register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) snap_q <= '0;
        else     snap_q <= snap_d;
    end

    assign {x_src, y_src, z_src} = snap_q;
`else
    assign x_src = x_data_i;
    assign y_src = y_data_i;
    assign z_src = z_data_i;
`endif

    acl_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] addr_q, addr_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] miso_sh_q, miso_sh_d;
    logic       miso_q, miso_d;
    logic [7:0] filter_q, filter_d;
    logic [7:0] power_q, power_d;
    logic [7:0] byte_in;
    logic [7:0] rd_byte;

    // Read map for the byte addressed by the current pointer.
    always_comb begin
        rd_byte = 8'h00;
        case (addr_q)
            ADDR_DEVID_AD:   rd_byte = DEVID_AD;
            ADDR_DEVID_MST:  rd_byte = DEVID_MST_VAL;
            ADDR_PARTID:     rd_byte = PARTID;
            ADDR_XDATA_L:    rd_byte = x_src[7:0];
            ADDR_XDATA_H:    rd_byte = sx_hi(x_src);
            ADDR_YDATA_L:    rd_byte = y_src[7:0];
            ADDR_YDATA_H:    rd_byte = sx_hi(y_src);
            ADDR_ZDATA_L:    rd_byte = z_src[7:0];
            ADDR_ZDATA_H:    rd_byte = sx_hi(z_src);
            ADDR_FILTER_CTL: rd_byte = filter_q;
            ADDR_POWER_CTL:  rd_byte = power_q;
            default:         rd_byte = 8'h00;
        endcase
    end

    // Transaction FSM: byte assembly on SCLK rise, MISO load/shift on SCLK fall.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        is_wr_d   = is_wr_q;
        miso_sh_d = miso_sh_q;
        filter_d  = filter_q;
        power_d   = power_q;
        byte_in   = {shift_q[6:0], mosi_s};

        if (csn_rise) begin
            // End of transaction: any partial byte is dropped.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            miso_sh_d = 8'h00;
        end else if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                state_d   = ST_CMD;
                bit_cnt_d = 3'd0;
                shift_d   = 8'h00;
            end
        end else if (sclk_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        if (byte_in == CMD_WRITE) begin
                            state_d = ST_ADDR;
                            is_wr_d = 1'b1;
                        end else if (byte_in == CMD_READ) begin
                            state_d = ST_ADDR;
                            is_wr_d = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                    ST_ADDR: begin
                        addr_d  = byte_in;
                        state_d = is_wr_q ? ST_WDATA : ST_RDATA;
                    end
                    ST_WDATA: begin
                        if (addr_q == ADDR_FILTER_CTL) filter_d = byte_in;
                        if (addr_q == ADDR_POWER_CTL)  power_d  = byte_in;
                        addr_d = addr_q + 8'd1;
                    end
                    ST_RDATA: begin
                        addr_d = addr_q + 8'd1;
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall && state_q == ST_RDATA) begin
            // Bit counter at zero means a byte boundary: load the next read byte.
            if (bit_cnt_q == 3'd0) miso_sh_d = rd_byte;
            else                   miso_sh_d = {miso_sh_q[6:0], 1'b0};
        end

        miso_d = (state_d == ST_RDATA) ? miso_sh_d[7] : 1'b0;
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            addr_q    <= 8'h00;
            is_wr_q   <= 1'b0;
            miso_sh_q <= 8'h00;
            miso_q    <= 1'b0;
            filter_q  <= FILTER_CTL_RST;
            power_q   <= POWER_CTL_RST;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            is_wr_q   <= is_wr_d;
            miso_sh_q <= miso_sh_d;
            miso_q    <= miso_d;
            filter_q  <= filter_d;
            power_q   <= power_d;
        end
    end

    assign acl_miso_o    = miso_q;
    assign acl_miso_oe_o = ~csn_lvl;
    assign filter_ctl_o  = filter_q;
    assign power_ctl_o   = power_q;
    assign dbg_state_o   = state_q;

endmodule
